cdb_issue_scheduler: RTL

- Issue scheduler for the four execution units: integer, multiplier, divider and memory.
- Each cycle it decides which ready issue queues may issue.
- It reserves a future common data bus (CDB) slot per grant through a reservation shift register, so two results never collide on the CDB.
- It drives the CDB mux select for the current cycle, so the CDB output stage needs no issue-history state of its own.

---
 rtl/cdb_issue_scheduler_pkg.sv | 33 +++
 rtl/cdb_issue_scheduler_rsv.sv | 63 ++++++
 rtl/cdb_issue_scheduler.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cdb_issue_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_issue_scheduler_pkg
//  Purpose  : Shared types and default latencies for the CDB issue scheduler.
//             unit_id_e    - execution unit identifier (also the CDB mux code)
//             rsv_entry_t  - one CDB reservation slot {valid, unit}
//  Revision : 1.0 - initial release
// ============================================================================
package cdb_issue_scheduler_pkg;

    typedef enum logic [1:0] {
        UNIT_INT  = 2'd0,
        UNIT_MULT = 2'd1,
        UNIT_DIV  = 2'd2,
        UNIT_MEM  = 2'd3
    } unit_id_e;

    typedef struct packed {
        logic     valid;
        unit_id_e unit;
    } rsv_entry_t;

    localparam int NUM_UNITS     = 4;
    localparam int DEF_INT_LAT   = 1;
    localparam int DEF_MEM_LAT   = 1;
    localparam int DEF_MULT_LAT  = 4;
    localparam int DEF_DIV_LAT   = 7;
    localparam int DEF_RSV_DEPTH = 8;

    localparam rsv_entry_t RSV_INVALID = '{valid: 1'b0, unit: UNIT_INT};

endpackage : cdb_issue_scheduler_pkg
`default_nettype wire

// File: rtl/cdb_issue_scheduler_rsv.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_rsv_shift_reg
//  Purpose  : CDB reservation shift register. Entry k names the CDB owner k
//             cycles from now. Every cycle the array shifts toward entry 0;
//             each granted unit then books entry (LAT-1) of the shifted image.
//  Ports    : clk, rst (async, active-low)
//             grant_i      [NUM_UNITS]  per-unit grant, indexed by unit_id_e
//             slot_valid_o [RSV_DEPTH]  valid bit of every entry
//             head_o                    entry 0 (current CDB owner)
//  Revision : 1.0 - initial release
// ============================================================================
module cdb_rsv_shift_reg
    import cdb_issue_scheduler_pkg::*;
#(
    parameter int INT_LAT   = DEF_INT_LAT,
    parameter int MEM_LAT   = DEF_MEM_LAT,
    parameter int MULT_LAT  = DEF_MULT_LAT,
    parameter int DIV_LAT   = DEF_DIV_LAT,
    parameter int RSV_DEPTH = DEF_RSV_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_UNITS-1:0] grant_i,
    output logic [RSV_DEPTH-1:0] slot_valid_o,
    output rsv_entry_t           head_o
);

    rsv_entry_t [RSV_DEPTH-1:0] rsv_q;
    rsv_entry_t [RSV_DEPTH-1:0] rsv_d;

    always_comb begin
        for (int k = 0; k < RSV_DEPTH - 1; k++) begin
            rsv_d[k] = rsv_q[k+1];
        end
        rsv_d[RSV_DEPTH-1] = RSV_INVALID;

        // Writes land in the already-shifted image, hence index LAT-1.
        // The picker guarantees that no two grants target the same entry.
        if (grant_i[UNIT_INT])  rsv_d[INT_LAT-1]  = '{valid: 1'b1, unit: UNIT_INT};
        if (grant_i[UNIT_MULT]) rsv_d[MULT_LAT-1] = '{valid: 1'b1, unit: UNIT_MULT};
        if (grant_i[UNIT_DIV])  rsv_d[DIV_LAT-1]  = '{valid: 1'b1, unit: UNIT_DIV};
        if (grant_i[UNIT_MEM])  rsv_d[MEM_LAT-1]  = '{valid: 1'b1, unit: UNIT_MEM};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsv_q <= '0;
        end else begin
            rsv_q <= rsv_d;
        end
    end

    always_comb begin
        for (int k = 0; k < RSV_DEPTH; k++) begin
            slot_valid_o[k] = rsv_q[k].valid;
        end
    end

    assign head_o = rsv_q[0];

endmodule : cdb_rsv_shift_reg
`default_nettype wire

// File: rtl/cdb_issue_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_issue_scheduler
//  Purpose  : Issue scheduler for int/mult/div/mem units. Grants ready queues
//             in rotating priority, books a future CDB slot per grant so no
//             two results collide, and drives the CDB mux select.
//  Ports    : clk, rst (async, active-low)
//             ready_{int,mult,div,mem}  queue has a ready instruction
//             div_busy                  divider occupied
//             issue_{int,mult,div,mem}  one-cycle grant pulses
//             cdb_sel[1:0], cdb_sel_valid  current CDB owner
//             (ISSUE_SCHED_STATS_EN) grant_cnt_{int,mult,div,mem}, stall_cnt
//  Options  : `define ISSUE_SCHED_STATS_EN adds 32-bit grant/stall counters.
//  Revision : 1.0 - initial release
// ============================================================================
module cdb_issue_scheduler
    import cdb_issue_scheduler_pkg::*;
#(
    parameter int INT_LAT   = DEF_INT_LAT,
    parameter int MEM_LAT   = DEF_MEM_LAT,
    parameter int MULT_LAT  = DEF_MULT_LAT,
    parameter int DIV_LAT   = DEF_DIV_LAT,
    parameter int RSV_DEPTH = DEF_RSV_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready_int,
    input  logic        ready_mult,
    input  logic        ready_div,
    input  logic        ready_mem,
    input  logic        div_busy,
    output logic        issue_int,
    output logic        issue_mult,
    output logic        issue_div,
    output logic        issue_mem,
`ifdef ISSUE_SCHED_STATS_EN
    output logic [31:0] grant_cnt_int,
    output logic [31:0] grant_cnt_mult,
    output logic [31:0] grant_cnt_div,
    output logic [31:0] grant_cnt_mem,
    output logic [31:0] stall_cnt,
`endif
    output logic [1:0]  cdb_sel,
    output logic        cdb_sel_valid
);

    localparam int IDX_W = $clog2(RSV_DEPTH);

    // Slot L must exist for the grant-time check, and slot L-1 for the write.
    if (INT_LAT < 1 || MEM_LAT < 1 || MULT_LAT < 1 || DIV_LAT < 1 ||
        RSV_DEPTH <= INT_LAT || RSV_DEPTH <= MEM_LAT ||
        RSV_DEPTH <= MULT_LAT || RSV_DEPTH <= DIV_LAT) begin : g_cfg_check
        $error("cdb_issue_scheduler: RSV_DEPTH must exceed every latency, latencies must be >= 1");
    end

    function automatic logic [IDX_W-1:0] lat_of(input unit_id_e u);
        case (u)
            UNIT_INT:  lat_of = IDX_W'(INT_LAT);
            UNIT_MULT: lat_of = IDX_W'(MULT_LAT);
            UNIT_DIV:  lat_of = IDX_W'(DIV_LAT);
            default:   lat_of = IDX_W'(MEM_LAT);
        endcase
    endfunction

    logic [1:0]           ptr_q;
    logic [1:0]           ptr_d;
    logic [NUM_UNITS-1:0] req;
    logic [NUM_UNITS-1:0] grant;
    logic [RSV_DEPTH-1:0] slot_valid;
    logic [RSV_DEPTH-1:0] claimed;
    logic                 any_grant;
    unit_id_e             first_unit;
    unit_id_e             cand;
    logic [IDX_W-1:0]     cand_lat;
    rsv_entry_t           head;

    always_comb begin
        req            = '0;
        req[UNIT_INT]  = ready_int;
        req[UNIT_MULT] = ready_mult;
        req[UNIT_DIV]  = ready_div & ~div_busy;
        req[UNIT_MEM]  = ready_mem;
    end

    // Rotating scan from ptr_q. 'claimed' tracks slots booked by
    // higher-priority grants in this same cycle.
    always_comb begin
        grant      = '0;
        claimed    = '0;
        any_grant  = 1'b0;
        first_unit = UNIT_INT;
        cand       = UNIT_INT;
        cand_lat   = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            cand     = unit_id_e'(ptr_q + 2'(i));
            cand_lat = lat_of(cand);
            // Grants are suppressed while reset is held so no pulse escapes.
            if (rst && req[cand] && !slot_valid[cand_lat] && !claimed[cand_lat]) begin
                grant[cand]       = 1'b1;
                claimed[cand_lat] = 1'b1;
                if (!any_grant) begin
                    first_unit = cand;
                    any_grant  = 1'b1;
                end
            end
        end
        ptr_d = any_grant ? (first_unit + 2'd1) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    cdb_rsv_shift_reg #(
        .INT_LAT   (INT_LAT),
        .MEM_LAT   (MEM_LAT),
        .MULT_LAT  (MULT_LAT),
        .DIV_LAT   (DIV_LAT),
        .RSV_DEPTH (RSV_DEPTH)
    ) u_rsv (
        .clk          (clk),
        .rst          (rst),
        .grant_i      (grant),
        .slot_valid_o (slot_valid),
        .head_o       (head)
    );

    assign issue_int     = grant[UNIT_INT];
    assign issue_mult    = grant[UNIT_MULT];
    assign issue_div     = grant[UNIT_DIV];
    assign issue_mem     = grant[UNIT_MEM];
    assign cdb_sel_valid = head.valid;
    assign cdb_sel       = head.valid ? head.unit : 2'd0;

`ifdef ISSUE_SCHED_STATS_EN
    logic [31:0] grant_cnt_int_q;
    logic [31:0] grant_cnt_mult_q;
    logic [31:0] grant_cnt_div_q;
    logic [31:0] grant_cnt_mem_q;
    logic [31:0] stall_cnt_q;
    logic        stall;

    // Raw ready is used: a div request blocked by div_busy still counts.
    assign stall = (ready_int | ready_mult | ready_div | ready_mem) & ~any_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt_int_q  <= '0;
            grant_cnt_mult_q <= '0;
            grant_cnt_div_q  <= '0;
            grant_cnt_mem_q  <= '0;
            stall_cnt_q      <= '0;
        end else begin
            grant_cnt_int_q  <= grant_cnt_int_q  + 32'(grant[UNIT_INT]);
            grant_cnt_mult_q <= grant_cnt_mult_q + 32'(grant[UNIT_MULT]);
            grant_cnt_div_q  <= grant_cnt_div_q  + 32'(grant[UNIT_DIV]);
            grant_cnt_mem_q  <= grant_cnt_mem_q  + 32'(grant[UNIT_MEM]);
            stall_cnt_q      <= stall_cnt_q      + 32'(stall);
        end
    end

    assign grant_cnt_int  = grant_cnt_int_q;
    assign grant_cnt_mult = grant_cnt_mult_q;
    assign grant_cnt_div  = grant_cnt_div_q;
    assign grant_cnt_mem  = grant_cnt_mem_q;
    assign stall_cnt      = stall_cnt_q;
`endif

endmodule : cdb_issue_scheduler
`default_nettype wire
